ds1307_timekeeper: RTL and testbench

- Timekeeping core of the DS1307 RTC emulation.
- Sits directly upstream of the I2C register file and drives its eight read-back registers (0x00–0x07) with live BCD time/date/control values.
- Accepts host writes forwarded from the I2C write path.
- Divides the system clock to 1 Hz and advances seconds through years with full calendar carry.

---
 rtl/ds1307_pkg.sv | 68 ++++++
 rtl/ds1307_timekeeper_bcd_field_inc.sv | 25 ++
 rtl/ds1307_timekeeper.sv | 215 +++++++++++++++++++++
 tb/tb_ds1307_timekeeper.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ds1307_pkg.sv
// Shared constants for the DS1307 timekeeping core: register indices, bit
// positions, BCD field limits, write masks and the month-length lookup.
package ds1307_pkg;

  // Register indices as seen by the I2C register file
  localparam logic [2:0] REG_SEC   = 3'd0;
  localparam logic [2:0] REG_MIN   = 3'd1;
  localparam logic [2:0] REG_HOUR  = 3'd2;
  localparam logic [2:0] REG_DAY   = 3'd3;
  localparam logic [2:0] REG_DATE  = 3'd4;
  localparam logic [2:0] REG_MONTH = 3'd5;
  localparam logic [2:0] REG_YEAR  = 3'd6;
  localparam logic [2:0] REG_CTRL  = 3'd7;

  // Bit positions inside the registers
  localparam int CH_BIT     = 7;  // reg_sec
  localparam int MODE12_BIT = 6;  // reg_hour
  localparam int PM_BIT     = 5;  // reg_hour, 12h mode only
  localparam int OUT_BIT    = 7;  // reg_ctrl
  localparam int SQWE_BIT   = 4;  // reg_ctrl

  // BCD field limits
  localparam logic [7:0] SEC_MIN    = 8'h00;
  localparam logic [7:0] SEC_MAX    = 8'h59;
  localparam logic [7:0] MIN_MIN    = 8'h00;
  localparam logic [7:0] MIN_MAX    = 8'h59;
  localparam logic [7:0] HOUR24_MIN = 8'h00;
  localparam logic [7:0] HOUR24_MAX = 8'h23;
  localparam logic [7:0] HOUR12_MIN = 8'h01;
  localparam logic [7:0] HOUR12_MAX = 8'h12;
  localparam logic [7:0] DAY_MIN    = 8'h01;
  localparam logic [7:0] DAY_MAX    = 8'h07;
  localparam logic [7:0] DATE_MIN   = 8'h01;
  localparam logic [7:0] MONTH_MIN  = 8'h01;
  localparam logic [7:0] MONTH_MAX  = 8'h12;
  localparam logic [7:0] YEAR_MIN   = 8'h00;
  localparam logic [7:0] YEAR_MAX   = 8'h99;

  // Storable bits per register; everything else reads back as 0
  localparam logic [7:0] MASK_SEC   = 8'hFF;
  localparam logic [7:0] MASK_MIN   = 8'h7F;
  localparam logic [7:0] MASK_HOUR  = 8'h7F;
  localparam logic [7:0] MASK_DAY   = 8'h07;
  localparam logic [7:0] MASK_DATE  = 8'h3F;
  localparam logic [7:0] MASK_MONTH = 8'h1F;
  localparam logic [7:0] MASK_YEAR  = 8'hFF;
  localparam logic [7:0] MASK_CTRL  = 8'h93;

  // Leap year when the two-digit BCD year is a multiple of 4 (00 included)
  function automatic logic bcd_leap(input logic [7:0] year);
    logic [7:0] bin;
    bin = ({4'd0, year[7:4]} * 8'd10) + {4'd0, year[3:0]};
    return (bin[1:0] == 2'b00);
  endfunction

  // Last valid BCD date of a BCD month; unknown months get 31 days
  function automatic logic [7:0] month_days(input logic [7:0] month,
                                            input logic [7:0] year);
    logic [7:0] days;
    case (month)
      8'h02:                      days = bcd_leap(year) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: days = 8'h30;
      default:                    days = 8'h31;
    endcase
    return days;
  endfunction

endpackage

// File: rtl/ds1307_timekeeper_bcd_field_inc.sv
// BCD increment of one calendar/time field with wrap to the field minimum.
// Anything at or above the maximum (including invalid BCD) wraps and carries.
module bcd_field_inc (
  input  logic [7:0] value_i,
  input  logic [7:0] min_i,
  input  logic [7:0] max_i,
  output logic [7:0] next_o,
  output logic       carry_o
);

  // Next BCD value and carry out of this field
  always_comb begin
    next_o  = value_i;
    carry_o = 1'b0;
    if (value_i >= max_i) begin
      next_o  = min_i;
      carry_o = 1'b1;
    end else if (value_i[3:0] >= 4'd9) begin
      next_o = {value_i[7:4] + 4'd1, 4'd0};
    end else begin
      next_o = value_i + 8'd1;
    end
  end

endmodule

// File: rtl/ds1307_timekeeper.sv
// DS1307 timekeeping core: 1 Hz prescaler, seconds-to-years BCD calendar,
// host write port and OUT/SQW pin. The square-wave generator is only built
// when DS1307_SQW_EN is defined; otherwise the pin follows the OUT bit.
module ds1307_timekeeper
  import ds1307_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 28000000,
  parameter int PRESCALE_W  = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] reg_sec,
  output logic [7:0] reg_min,
  output logic [7:0] reg_hour,
  output logic [7:0] reg_day,
  output logic [7:0] reg_date,
  output logic [7:0] reg_month,
  output logic [7:0] reg_year,
  output logic [7:0] reg_ctrl,
  output logic       tick_1hz,
  output logic       sqw_out
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_TC = PRESCALE_W'(CLK_FREQ_HZ - 1);

  logic [7:0] sec_q, min_q, hour_q, day_q, date_q, month_q, year_q, ctrl_q;
  logic [7:0] sec_d, min_d, hour_d, day_d, date_d, month_d, year_d, ctrl_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic pending_q, pending_d;
  logic tick_q, tick_d;

  logic tick_int;
  logic do_tick;

  // Terminal count of the running prescaler is the internal 1 Hz tick
  assign tick_int = !sec_q[CH_BIT] && (presc_q == PRESCALE_TC);
  // A tick (fresh or deferred) only lands on a cycle free of host writes
  assign do_tick  = !wr_en && (tick_int || pending_q);

  // Per-field incrementers
  logic [7:0] sec_nx, min_nx, hour_nx, day_nx, date_nx, month_nx, year_nx;
  logic       sec_c, min_c, hour_c, date_c, month_c;
  logic       day_carry_unused, year_carry_unused;

  logic       mode12;
  logic [7:0] hour_val, hour_lo, hour_hi;
  logic       hour_is_11;
  logic       pm_next;
  logic       hour_carry;

  assign mode12     = hour_q[MODE12_BIT];
  assign hour_val   = mode12 ? {3'b000, hour_q[4:0]} : {2'b00, hour_q[5:0]};
  assign hour_lo    = mode12 ? HOUR12_MIN : HOUR24_MIN;
  assign hour_hi    = mode12 ? HOUR12_MAX : HOUR24_MAX;
  assign hour_is_11 = (hour_val == 8'h11);
  // In 12h mode PM flips on 11->12; the day only rolls on 11 PM -> 12 AM
  assign pm_next    = hour_q[PM_BIT] ^ hour_is_11;
  assign hour_carry = mode12 ? (hour_q[PM_BIT] && hour_is_11) : hour_c;

  bcd_field_inc u_sec_inc (
    .value_i({1'b0, sec_q[6:0]}), .min_i(SEC_MIN), .max_i(SEC_MAX),
    .next_o(sec_nx), .carry_o(sec_c)
  );
  bcd_field_inc u_min_inc (
    .value_i(min_q), .min_i(MIN_MIN), .max_i(MIN_MAX),
    .next_o(min_nx), .carry_o(min_c)
  );
  bcd_field_inc u_hour_inc (
    .value_i(hour_val), .min_i(hour_lo), .max_i(hour_hi),
    .next_o(hour_nx), .carry_o(hour_c)
  );
  bcd_field_inc u_day_inc (
    .value_i(day_q), .min_i(DAY_MIN), .max_i(DAY_MAX),
    .next_o(day_nx), .carry_o(day_carry_unused)
  );
  bcd_field_inc u_date_inc (
    .value_i(date_q), .min_i(DATE_MIN), .max_i(month_days(month_q, year_q)),
    .next_o(date_nx), .carry_o(date_c)
  );
  bcd_field_inc u_month_inc (
    .value_i(month_q), .min_i(MONTH_MIN), .max_i(MONTH_MAX),
    .next_o(month_nx), .carry_o(month_c)
  );
  bcd_field_inc u_year_inc (
    .value_i(year_q), .min_i(YEAR_MIN), .max_i(YEAR_MAX),
    .next_o(year_nx), .carry_o(year_carry_unused)
  );

  // Next state: prescaler, pending tick, host writes and calendar advance
  always_comb begin
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    day_d     = day_q;
    date_d    = date_q;
    month_d   = month_q;
    year_d    = year_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    tick_d    = do_tick;

    if (sec_q[CH_BIT] || tick_int) presc_d = '0;
    else                           presc_d = presc_q + PRESCALE_W'(1);

    if (wr_en) begin
      // A tick colliding with a seconds write is dropped: the second restarts
      if (tick_int && (wr_addr != REG_SEC)) pending_d = 1'b1;
      case (wr_addr)
        REG_SEC: begin
          sec_d     = wr_data & MASK_SEC;
          presc_d   = '0;
          pending_d = 1'b0;
        end
        REG_MIN:   min_d   = wr_data & MASK_MIN;
        REG_HOUR:  hour_d  = wr_data & MASK_HOUR;
        REG_DAY:   day_d   = wr_data & MASK_DAY;
        REG_DATE:  date_d  = wr_data & MASK_DATE;
        REG_MONTH: month_d = wr_data & MASK_MONTH;
        REG_YEAR:  year_d  = wr_data & MASK_YEAR;
        REG_CTRL:  ctrl_d  = wr_data & MASK_CTRL;
      endcase
    end else if (do_tick) begin
      pending_d = 1'b0;
      sec_d     = sec_nx;
      if (sec_c) begin
        min_d = min_nx;
        if (min_c) begin
          hour_d = mode12 ? {2'b01, pm_next, hour_nx[4:0]} : hour_nx;
          if (hour_carry) begin
            day_d  = day_nx;
            date_d = date_nx;
            if (date_c) begin
              month_d = month_nx;
              if (month_c) year_d = year_nx;
            end
          end
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      hour_q    <= 8'h00;
      day_q     <= 8'h01;
      date_q    <= 8'h01;
      month_q   <= 8'h01;
      year_q    <= 8'h00;
      ctrl_q    <= 8'h00;
      presc_q   <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      day_q     <= day_d;
      date_q    <= date_d;
      month_q   <= month_d;
      year_q    <= year_d;
      ctrl_q    <= ctrl_d;
      presc_q   <= presc_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
    end
  end

  assign reg_sec   = sec_q;
  assign reg_min   = min_q;
  assign reg_hour  = hour_q;
  assign reg_day   = day_q;
  assign reg_date  = date_q;
  assign reg_month = month_q;
  assign reg_year  = year_q;
  assign reg_ctrl  = ctrl_q;
  assign tick_1hz  = tick_q;

`ifdef DS1307_SQW_EN
  // Phase increments f * 2^32 / CLK_FREQ_HZ for the four RS selections
  localparam logic [31:0] INC_1HZ  = 32'((64'd1     << 32) / 64'(CLK_FREQ_HZ));
  localparam logic [31:0] INC_4K   = 32'((64'd4096  << 32) / 64'(CLK_FREQ_HZ));
  localparam logic [31:0] INC_8K   = 32'((64'd8192  << 32) / 64'(CLK_FREQ_HZ));
  localparam logic [31:0] INC_32K  = 32'((64'd32768 << 32) / 64'(CLK_FREQ_HZ));

  logic [31:0] acc_q, acc_d, acc_inc;

  assign acc_inc = (ctrl_q[1:0] == 2'd0) ? INC_1HZ :
                   (ctrl_q[1:0] == 2'd1) ? INC_4K  :
                   (ctrl_q[1:0] == 2'd2) ? INC_8K  : INC_32K;

  // Accumulator restarts on any control write; the 1 Hz wave follows CH
  always_comb begin
    acc_d = acc_q + acc_inc;
    if (!ctrl_q[SQWE_BIT] || (wr_en && (wr_addr == REG_CTRL))) acc_d = '0;
    else if ((ctrl_q[1:0] == 2'd0) && sec_q[CH_BIT])            acc_d = acc_q;
  end

  // Phase accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign sqw_out = ctrl_q[SQWE_BIT] ? acc_q[31] : ctrl_q[OUT_BIT];
`else
  assign sqw_out = ctrl_q[OUT_BIT];
`endif

endmodule

// File: tb/tb_ds1307_timekeeper.sv
// Bench for ds1307_timekeeper at a 10 Hz "system clock": tick timing, reset,
// clock halt, write/tick collisions, write masking and a calendar vector
// table checked through an expected-value scoreboard.
module tb_ds1307_timekeeper;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] reg_sec, reg_min, reg_hour, reg_day, reg_date, reg_month, reg_year, reg_ctrl;
  logic       tick_1hz, sqw_out;

  int checks = 0;
  int errors = 0;

  typedef logic [6:0][7:0] regs_t;  // [0]=sec .. [6]=year
  typedef struct packed {
    regs_t w;
    regs_t e;
  } vec_t;

  localparam int NV = 13;
  vec_t  vecs [NV];
  regs_t sb_q [$];
  string rn [7];

  always #5 clk = ~clk;

  ds1307_timekeeper #(.CLK_FREQ_HZ(CLK_HZ), .PRESCALE_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_sec(reg_sec), .reg_min(reg_min), .reg_hour(reg_hour), .reg_day(reg_day),
    .reg_date(reg_date), .reg_month(reg_month), .reg_year(reg_year), .reg_ctrl(reg_ctrl),
    .tick_1hz(tick_1hz), .sqw_out(sqw_out)
  );

  function automatic regs_t mk(input logic [7:0] s, mi, h, dy, dt, mo, y);
    return {y, mo, dt, dy, h, mi, s};
  endfunction

  function automatic regs_t cur();
    return {reg_year, reg_month, reg_date, reg_day, reg_hour, reg_min, reg_sec};
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%02h expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Count cycles until the first tick_1hz (0 = none within the budget)
  task automatic first_tick(input int budget, output int at);
    at = 0;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (tick_1hz && at == 0) at = c;
    end
  endtask

  initial begin
    int at;
    int nt;
    regs_t exp;
    logic got_tick;
    logic [7:0] wmask [1:7];

    rn = '{"sec", "min", "hour", "day", "date", "month", "year"};
    vecs[0].w  = mk(8'h59, 8'h59, 8'h23, 8'h07, 8'h31, 8'h12, 8'h99);
    vecs[0].e  = mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00);
    vecs[1].w  = mk(8'h59, 8'h59, 8'h23, 8'h03, 8'h28, 8'h02, 8'h24);
    vecs[1].e  = mk(8'h00, 8'h00, 8'h00, 8'h04, 8'h29, 8'h02, 8'h24);
    vecs[2].w  = mk(8'h59, 8'h59, 8'h23, 8'h03, 8'h28, 8'h02, 8'h23);
    vecs[2].e  = mk(8'h00, 8'h00, 8'h00, 8'h04, 8'h01, 8'h03, 8'h23);
    vecs[3].w  = mk(8'h59, 8'h59, 8'h71, 8'h02, 8'h15, 8'h06, 8'h10);
    vecs[3].e  = mk(8'h00, 8'h00, 8'h52, 8'h03, 8'h16, 8'h06, 8'h10);
    vecs[4].w  = mk(8'h59, 8'h59, 8'h51, 8'h02, 8'h15, 8'h06, 8'h10);
    vecs[4].e  = mk(8'h00, 8'h00, 8'h72, 8'h02, 8'h15, 8'h06, 8'h10);
    vecs[5].w  = mk(8'h59, 8'h59, 8'h72, 8'h02, 8'h15, 8'h06, 8'h10);
    vecs[5].e  = mk(8'h00, 8'h00, 8'h61, 8'h02, 8'h15, 8'h06, 8'h10);
    vecs[6].w  = mk(8'h30, 8'h10, 8'h05, 8'h04, 8'h10, 8'h04, 8'h20);
    vecs[6].e  = mk(8'h31, 8'h10, 8'h05, 8'h04, 8'h10, 8'h04, 8'h20);
    vecs[7].w  = mk(8'h59, 8'h59, 8'h23, 8'h05, 8'h30, 8'h04, 8'h21);
    vecs[7].e  = mk(8'h00, 8'h00, 8'h00, 8'h06, 8'h01, 8'h05, 8'h21);
    vecs[8].w  = mk(8'h59, 8'h59, 8'h23, 8'h01, 8'h28, 8'h02, 8'h00);
    vecs[8].e  = mk(8'h00, 8'h00, 8'h00, 8'h02, 8'h29, 8'h02, 8'h00);
    vecs[9].w  = mk(8'h5A, 8'h09, 8'h10, 8'h01, 8'h01, 8'h01, 8'h01);
    vecs[9].e  = mk(8'h00, 8'h10, 8'h10, 8'h01, 8'h01, 8'h01, 8'h01);
    vecs[10].w = mk(8'h59, 8'h19, 8'h08, 8'h03, 8'h05, 8'h07, 8'h15);
    vecs[10].e = mk(8'h00, 8'h20, 8'h08, 8'h03, 8'h05, 8'h07, 8'h15);
    vecs[11].w = mk(8'h59, 8'h59, 8'h23, 8'h02, 8'h29, 8'h02, 8'h24);
    vecs[11].e = mk(8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h03, 8'h24);
    vecs[12].w = mk(8'h59, 8'h59, 8'h09, 8'h06, 8'h31, 8'h01, 8'h50);
    vecs[12].e = mk(8'h00, 8'h00, 8'h10, 8'h06, 8'h31, 8'h01, 8'h50);
    wmask[1] = 8'h7F; wmask[2] = 8'h7F; wmask[3] = 8'h07; wmask[4] = 8'h3F;
    wmask[5] = 8'h1F; wmask[6] = 8'hFF; wmask[7] = 8'h93;

    // Reset values
    rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp = mk(8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00);
    for (int r = 0; r < 7; r++) check8({"reset ", rn[r]}, cur()[r], exp[r]);
    check8("reset ctrl", reg_ctrl, 8'h00);
    check8("reset tick", {7'd0, tick_1hz}, 8'h00);
    check8("reset sqw", {7'd0, sqw_out}, 8'h00);
    rst = 1'b0;

    // 25 cycles: ticks on cycles 10 and 20 only
    nt = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (tick_1hz) begin
        nt++;
        checks++;
        if (c != 10 && c != 20) begin
          errors++;
          $display("FAIL tick_cycle got %0d required 10 or 20", c);
        end
      end
    end
    check8("tick_count", 8'(nt), 8'd2);
    check8("sec_after_25", reg_sec, 8'h02);
    $display("txn run25 ticks=%0d sec=%02h", nt, reg_sec);

    // Reset mid-second discards the partial count
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    first_tick(12, at);
    check8("reset_midcount_tick_cycle", 8'(at), 8'd10);
    check8("reset_midcount_sec", reg_sec, 8'h01);
    $display("txn reset_mid first_tick=%0d sec=%02h", at, reg_sec);

    // Clock halt: no ticks, then restart gives a full second
    wr(3'd0, 8'h80);
    nt = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (tick_1hz) nt++;
    end
    check8("halt_ticks", 8'(nt), 8'd0);
    check8("halt_sec", reg_sec, 8'h80);
    wr(3'd0, 8'h30);
    first_tick(12, at);
    check8("restart_tick_cycle", 8'(at), 8'd10);
    check8("restart_sec", reg_sec, 8'h31);
    $display("txn halt ticks=%0d restart_tick=%0d sec=%02h", nt, at, reg_sec);

    // Collision with a minutes write: tick deferred by one cycle
    wr(3'd0, 8'h10);
    repeat (9) @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h42;
    @(posedge clk); #1;
    check8("coll_min_written", reg_min, 8'h42);
    check8("coll_sec_held", reg_sec, 8'h10);
    check8("coll_tick_held", {7'd0, tick_1hz}, 8'h00);
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #1;
    check8("coll_sec_late", reg_sec, 8'h11);
    check8("coll_tick_late", {7'd0, tick_1hz}, 8'h01);
    check8("coll_min_kept", reg_min, 8'h42);
    $display("txn collide_min sec=%02h min=%02h", reg_sec, reg_min);

    // Collision with a seconds write: tick discarded, second restarts
    wr(3'd0, 8'h10);
    repeat (9) @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h20;
    @(posedge clk); #1;
    check8("coll0_sec_written", reg_sec, 8'h20);
    check8("coll0_tick", {7'd0, tick_1hz}, 8'h00);
    @(negedge clk); wr_en = 1'b0;
    first_tick(10, at);
    check8("coll0_next_tick_cycle", 8'(at), 8'd10);
    check8("coll0_sec", reg_sec, 8'h21);
    $display("txn collide_sec first_tick=%0d sec=%02h", at, reg_sec);

    // Calendar vector table through the scoreboard
    for (int i = 0; i < NV; i++) begin
      wr(3'd0, 8'h80);
      for (int a = 1; a < 7; a++) wr(3'(a), vecs[i].w[a]);
      sb_q.push_back(vecs[i].e);
      wr(3'd0, vecs[i].w[0]);
      got_tick = 1'b0;
      for (int c = 0; c < 20 && !got_tick; c++) begin
        @(posedge clk); #1;
        if (tick_1hz) got_tick = 1'b1;
      end
      checks++;
      if (!got_tick) begin
        errors++;
        $display("FAIL vec%0d tick got none required one within 20 cycles", i);
        void'(sb_q.pop_front());
      end else begin
        exp = sb_q.pop_front();
        for (int r = 0; r < 7; r++)
          check8($sformatf("vec%0d %s", i, rn[r]), cur()[r], exp[r]);
      end
      $display("txn vec%0d %02h:%02h:%02h day=%02h %02h/%02h/%02h", i,
               reg_hour, reg_min, reg_sec, reg_day, reg_date, reg_month, reg_year);
    end

    // Write masking while halted (writes stored, time frozen)
    wr(3'd0, 8'h80);
    for (int a = 1; a < 8; a++) begin
      wr(3'(a), 8'hFF);
      case (a)
        1: check8("mask min", reg_min, wmask[1]);
        2: check8("mask hour", reg_hour, wmask[2]);
        3: check8("mask day", reg_day, wmask[3]);
        4: check8("mask date", reg_date, wmask[4]);
        5: check8("mask month", reg_month, wmask[5]);
        6: check8("mask year", reg_year, wmask[6]);
        default: check8("mask ctrl", reg_ctrl, wmask[7]);
      endcase
    end
`ifndef DS1307_SQW_EN
    check8("sqw_ignores_sqwe", {7'd0, sqw_out}, 8'h01);
`endif
    check8("halted_sec_frozen", reg_sec, 8'h80);
    wr(3'd7, 8'h80);
    check8("sqw_out_high", {7'd0, sqw_out}, 8'h01);
    wr(3'd7, 8'h00);
    check8("sqw_out_low", {7'd0, sqw_out}, 8'h00);
    $display("txn mask ctrl=%02h sqw=%0d", reg_ctrl, sqw_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

endmodule
